aha_sram_arbiter: RTL and testbench

Two-requester arbiter and init sequencer for the 4K x 64-bit byte-writable SRAM wrapper (active-low CEn, active-low per-byte WEn, 12-bit address, 1-cycle read latency). After reset it optionally zero-fills the array. It then shares the single SRAM port between two valid/ready requesters, for example CPU and DMA, using round-robin arbitration. Read data returns on a registered per-port response channel, and the block sustains one access per cycle.

---
 rtl/aha_sram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_aha_sram_arbiter.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aha_sram_arbiter.sv
// aha_sram_arbiter: post-reset zero-fill sequencer plus round-robin
// two-port arbiter in front of a 4K x 64 byte-writable SRAM.
module aha_sram_arbiter #(
   parameter bit INIT_ZERO = 1'b1,
   parameter int INIT_LAST = 4095
) (
   input  logic        CLK,
   input  logic        RESETn,
   input  logic        REQ0_VALID,
   output logic        REQ0_READY,
   input  logic        REQ0_WRITE,
   input  logic [11:0] REQ0_ADDR,
   input  logic [63:0] REQ0_WDATA,
   input  logic [7:0]  REQ0_WSTRB,
   input  logic        REQ1_VALID,
   output logic        REQ1_READY,
   input  logic        REQ1_WRITE,
   input  logic [11:0] REQ1_ADDR,
   input  logic [63:0] REQ1_WDATA,
   input  logic [7:0]  REQ1_WSTRB,
   output logic        RSP0_VALID,
   output logic [63:0] RSP0_RDATA,
   output logic        RSP1_VALID,
   output logic [63:0] RSP1_RDATA,
   output logic        INIT_DONE,
   output logic        SRAM_CEn,
   output logic [7:0]  SRAM_WEn,
   output logic [11:0] SRAM_A,
   output logic [63:0] SRAM_D,
   input  logic [63:0] SRAM_Q
);

   typedef enum logic [1:0] {
      INIT_WAIT,
      INIT_FILL,
      RUN
   } state_t;

   localparam logic [11:0] FILL_LAST = 12'(INIT_LAST);

   state_t      state;
   state_t      state_nx;
   logic [11:0] fill_cnt;
   logic [11:0] fill_cnt_nx;
   logic        init_done;
   logic        last;
   logic        grant0;
   logic        grant1;
   logic        hs0;
   logic        hs1;
   logic        hs;
   logic        hs_write;
   logic [11:0] hs_addr;
   logic [63:0] hs_wdata;
   logic [7:0]  hs_wstrb;
   logic        fill_act;
   logic        rd_v;
   logic        rd_port;
   logic        rsp0_v;
   logic        rsp1_v;
   logic [63:0] rdata0;
   logic [63:0] rdata1;

   always_comb begin
      state_nx    = state;
      fill_cnt_nx = fill_cnt;
      unique case (state)
         INIT_WAIT: state_nx = INIT_ZERO ? INIT_FILL : RUN;
         INIT_FILL: begin
            fill_cnt_nx = fill_cnt + 12'd1;
            if (fill_cnt == FILL_LAST)
               state_nx = RUN;
         end
         RUN:       state_nx = RUN;
         default:   state_nx = INIT_WAIT;
      endcase
   end

   // Tie goes to the port that did not win the previous handshake.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      unique case ({REQ1_VALID, REQ0_VALID})
         2'b01:   grant0 = 1'b1;
         2'b10:   grant1 = 1'b1;
         2'b11: begin
            grant0 = last;
            grant1 = ~last;
         end
         default: ;
      endcase
   end

   // init_done is only set in RUN, so it doubles as the accept gate.
   assign hs0      = init_done & grant0;
   assign hs1      = init_done & grant1;
   assign hs       = hs0 | hs1;
   assign hs_write = hs1 ? REQ1_WRITE : REQ0_WRITE;
   assign hs_addr  = hs1 ? REQ1_ADDR  : REQ0_ADDR;
   assign hs_wdata = hs1 ? REQ1_WDATA : REQ0_WDATA;
   assign hs_wstrb = hs1 ? REQ1_WSTRB : REQ0_WSTRB;
   assign fill_act = (state == INIT_FILL);

   assign REQ0_READY = hs0;
   assign REQ1_READY = hs1;

   always_comb begin
      SRAM_CEn = 1'b1;
      SRAM_WEn = 8'hFF;
      SRAM_A   = '0;
      SRAM_D   = '0;
      unique case (1'b1)
         fill_act: begin
            SRAM_CEn = 1'b0;
            SRAM_WEn = 8'h00;
            SRAM_A   = fill_cnt;
         end
         hs: begin
            SRAM_CEn = 1'b0;
            SRAM_A   = hs_addr;
            if (hs_write) begin
               SRAM_WEn = ~hs_wstrb;
               SRAM_D   = hs_wdata;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state     <= INIT_WAIT;
         fill_cnt  <= '0;
         init_done <= 1'b0;
         last      <= 1'b1;
      end else begin
         state     <= state_nx;
         fill_cnt  <= fill_cnt_nx;
         init_done <= (state == RUN);
         if (hs)
            last <= hs1;
      end
   end

   // Stage 1 tags the access, stage 2 catches SRAM_Q one cycle later.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         rd_v    <= 1'b0;
         rd_port <= 1'b0;
         rsp0_v  <= 1'b0;
         rsp1_v  <= 1'b0;
         rdata0  <= '0;
         rdata1  <= '0;
      end else begin
         rd_v    <= hs & ~hs_write;
         rd_port <= hs1;
         rsp0_v  <= rd_v & ~rd_port;
         rsp1_v  <= rd_v & rd_port;
         if (rd_v & ~rd_port)
            rdata0 <= SRAM_Q;
         if (rd_v & rd_port)
            rdata1 <= SRAM_Q;
      end
   end

   assign RSP0_VALID = rsp0_v;
   assign RSP1_VALID = rsp1_v;
   assign RSP0_RDATA = rdata0;
   assign RSP1_RDATA = rdata1;
   assign INIT_DONE  = init_done;

endmodule

// File: tb/tb_aha_sram_arbiter.sv
// Bench for aha_sram_arbiter: SRAM model, transaction-level reference
// model of arbitration and memory contents, per-scenario tasks.
module tb_aha_sram_arbiter;

   localparam int LAST = 15;

   typedef struct packed {
      logic        v;
      logic        w;
      logic [11:0] a;
      logic [63:0] d;
      logic [7:0]  s;
   } req_t;

   localparam req_t IDLE = '0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        v0, w0, v1, w1;
   logic [11:0] a0, a1;
   logic [63:0] d0, d1;
   logic [7:0]  s0, s1;
   logic        rdy0, rdy1, rv0, rv1, done;
   logic [63:0] rd0, rd1;
   logic        cen;
   logic [7:0]  wen;
   logic [11:0] sa;
   logic [63:0] sd;
   logic [63:0] sq = '0;

   always #5 clk = ~clk;

   aha_sram_arbiter #(.INIT_ZERO(1'b1), .INIT_LAST(LAST)) dut (
      .CLK(clk), .RESETn(rst_n),
      .REQ0_VALID(v0), .REQ0_READY(rdy0), .REQ0_WRITE(w0),
      .REQ0_ADDR(a0), .REQ0_WDATA(d0), .REQ0_WSTRB(s0),
      .REQ1_VALID(v1), .REQ1_READY(rdy1), .REQ1_WRITE(w1),
      .REQ1_ADDR(a1), .REQ1_WDATA(d1), .REQ1_WSTRB(s1),
      .RSP0_VALID(rv0), .RSP0_RDATA(rd0),
      .RSP1_VALID(rv1), .RSP1_RDATA(rd1),
      .INIT_DONE(done),
      .SRAM_CEn(cen), .SRAM_WEn(wen), .SRAM_A(sa), .SRAM_D(sd),
      .SRAM_Q(sq)
   );

   function automatic logic [63:0] bmask(input logic [7:0] s);
      logic [63:0] m;
      for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{s[i]}};
      return m;
   endfunction

   function automatic req_t mk_rd(input logic [11:0] a);
      req_t q;
      q = '0; q.v = 1'b1; q.a = a;
      return q;
   endfunction

   function automatic req_t mk_wr(input logic [11:0] a, input logic [63:0] d,
                                  input logic [7:0] s);
      req_t q;
      q.v = 1'b1; q.w = 1'b1; q.a = a; q.d = d; q.s = s;
      return q;
   endfunction

   // SRAM device model
   logic [63:0] sram [4096];
   always @(posedge clk) begin
      if (!cen) begin
         if (&wen) sq <= sram[sa];
         else sram[sa] <= (sram[sa] & bmask(wen)) | (sd & ~bmask(wen));
      end
   end

   // Reference model state
   logic [63:0] ref_mem [4096];
   int          last_win;
   bit          pend_v, pend_p;
   logic [63:0] pend_d;
   bit          exp_g0, exp_g1, exp_rv0, exp_rv1;
   logic [63:0] exp_rd0, exp_rd1;
   logic        exp_cen;
   logic [7:0]  exp_wen;
   logic [11:0] exp_a;
   logic [63:0] exp_d;

   logic        o_r0, o_r1, o_cen, o_rv0, o_rv1;
   logic [7:0]  o_wen;
   logic [11:0] o_a;
   logic [63:0] o_d, o_rd0, o_rd1;

   int errors = 0;
   int checks = 0;
   bit watch = 0;
   int pulses = 0;

   always @(negedge clk) if (watch && (rv0 || rv1)) pulses++;

   task automatic model_reset();
      last_win = 1;
      pend_v = 0; pend_p = 0; pend_d = '0;
      exp_rv0 = 0; exp_rv1 = 0;
      exp_rd0 = '0; exp_rd1 = '0;
   endtask

   task automatic drive(input req_t q0, input req_t q1);
      v0 = q0.v; w0 = q0.w; a0 = q0.a; d0 = q0.d; s0 = q0.s;
      v1 = q1.v; w1 = q1.w; a1 = q1.a; d1 = q1.d; s1 = q1.s;
   endtask

   // One clock: drive at negedge, sample combinational outputs 1 ns later,
   // registered outputs 1 ns after the rising edge.
   task automatic cyc(input req_t q0, input req_t q1);
      req_t        g;
      bit          nv;
      logic [63:0] nd;
      @(negedge clk);
      drive(q0, q1);
      exp_g0 = q0.v && (!q1.v || last_win == 1);
      exp_g1 = q1.v && (!q0.v || last_win == 0);
      exp_cen = 1'b1; exp_wen = 8'hFF; exp_a = '0; exp_d = '0;
      nv = 0; nd = '0;
      if (exp_g0 || exp_g1) begin
         g = exp_g1 ? q1 : q0;
         last_win = exp_g1 ? 1 : 0;
         exp_cen = 1'b0; exp_a = g.a;
         if (g.w) begin
            exp_wen = ~g.s; exp_d = g.d;
            ref_mem[g.a] = (ref_mem[g.a] & ~bmask(g.s)) | (g.d & bmask(g.s));
         end else begin
            nv = 1; nd = ref_mem[g.a];
         end
      end
      #1;
      o_r0 = rdy0; o_r1 = rdy1;
      o_cen = cen; o_wen = wen; o_a = sa; o_d = sd;
      @(posedge clk);
      #1;
      exp_rv0 = pend_v && !pend_p;
      exp_rv1 = pend_v && pend_p;
      if (exp_rv0) exp_rd0 = pend_d;
      if (exp_rv1) exp_rd1 = pend_d;
      pend_v = nv; pend_p = exp_g1; pend_d = nd;
      o_rv0 = rv0; o_rv1 = rv1; o_rd0 = rd0; o_rd1 = rd1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(IDLE, IDLE);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({rdy0, rdy1, rv0, rv1, done} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags got %b want 00000", {rdy0, rdy1, rv0, rv1, done});
      end
      checks++;
      if (rd0 !== 64'd0 || rd1 !== 64'd0) begin
         errors++;
         $display("FAIL reset_rdata got %h %h want 0 0", rd0, rd1);
      end
      checks++;
      if (cen !== 1'b1 || wen !== 8'hFF || sa !== 12'd0 || sd !== 64'd0) begin
         errors++;
         $display("FAIL reset_sram got cen=%b wen=%h a=%h d=%h want 1 ff 0 0", cen, wen, sa, sd);
      end
   endtask

   task automatic test_zero_fill();
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 1; n <= LAST + 3; n++) begin
         @(posedge clk);
         #1;
         checks++;
         if (n <= LAST + 1) begin
            if (cen !== 1'b0 || wen !== 8'h00 || sa !== 12'(n - 1) || sd !== 64'd0) begin
               errors++;
               $display("FAIL fill_write cyc %0d got cen=%b wen=%h a=%h d=%h want 0 00 %h 0", n, cen, wen, sa, sd, 12'(n - 1));
            end
         end else if (cen !== 1'b1) begin
            errors++;
            $display("FAIL fill_idle cyc %0d got cen=%b want 1", n, cen);
         end
         checks++;
         if (done !== (n == LAST + 3)) begin
            errors++;
            $display("FAIL init_done cyc %0d got %b want %b", n, done, n == LAST + 3);
         end
      end
      for (int i = 0; i <= LAST; i++) ref_mem[i] = '0;
      for (int i = 0; i < 3; i++) begin
         cyc(i == 0 ? mk_rd(12'd7) : IDLE, IDLE);
         checks++;
         if ({o_rv0, o_rv1} !== {exp_rv0, exp_rv1} || o_rd0 !== exp_rd0) begin
            errors++;
            $display("FAIL fill_read cyc %0d got v=%b%b d=%h want %b%b %h", i, o_rv0, o_rv1, o_rd0, exp_rv0, exp_rv1, exp_rd0);
         end
      end
      checks++;
      if (exp_rd0 !== 64'd0) begin
         errors++;
         $display("FAIL fill_ref got %h want 0", exp_rd0);
      end
   endtask

   task automatic test_write_read();
      req_t t [4];
      t[0] = mk_wr(12'h100, 64'h0123456789ABCDEF, 8'hFF);
      t[1] = mk_rd(12'h100);
      t[2] = IDLE;
      t[3] = IDLE;
      for (int i = 0; i < 4; i++) begin
         cyc(t[i], IDLE);
         checks++;
         if ({o_r0, o_r1} !== {exp_g0, exp_g1}) begin
            errors++;
            $display("FAIL wr_rd_ready cyc %0d got %b%b want %b%b", i, o_r0, o_r1, exp_g0, exp_g1);
         end
         checks++;
         if ({o_cen, o_wen, o_a, o_d} !== {exp_cen, exp_wen, exp_a, exp_d}) begin
            errors++;
            $display("FAIL wr_rd_sram cyc %0d got %b %h %h %h want %b %h %h %h", i, o_cen, o_wen, o_a, o_d, exp_cen, exp_wen, exp_a, exp_d);
         end
         checks++;
         if ({o_rv0, o_rv1} !== {i == 2, 1'b0} || o_rd0 !== exp_rd0 || o_rd1 !== exp_rd1) begin
            errors++;
            $display("FAIL wr_rd_rsp cyc %0d got v=%b%b d=%h want %b0 %h", i, o_rv0, o_rv1, o_rd0, i == 2, exp_rd0);
         end
      end
      checks++;
      if (o_rd0 !== 64'h0123456789ABCDEF) begin
         errors++;
         $display("FAIL wr_rd_data got %h want 0123456789abcdef", o_rd0);
      end
   endtask

   task automatic test_partial_write();
      req_t t [5];
      t[0] = mk_wr(12'h200, 64'd0, 8'hFF);
      t[1] = mk_wr(12'h200, '1, 8'h0F);
      t[2] = mk_rd(12'h200);
      t[3] = IDLE;
      t[4] = IDLE;
      for (int i = 0; i < 5; i++) begin
         cyc(t[i], IDLE);
         checks++;
         if ({o_r0, o_r1} !== {exp_g0, exp_g1} || {o_cen, o_wen, o_a, o_d} !== {exp_cen, exp_wen, exp_a, exp_d}) begin
            errors++;
            $display("FAIL partial_acc cyc %0d got rdy=%b%b wen=%h a=%h want %b%b %h %h", i, o_r0, o_r1, o_wen, o_a, exp_g0, exp_g1, exp_wen, exp_a);
         end
         checks++;
         if ({o_rv0, o_rv1} !== {exp_rv0, exp_rv1} || o_rd0 !== exp_rd0 || o_rd1 !== exp_rd1) begin
            errors++;
            $display("FAIL partial_rsp cyc %0d got v=%b%b d=%h want %b%b %h", i, o_rv0, o_rv1, o_rd0, exp_rv0, exp_rv1, exp_rd0);
         end
         if (i == 1) begin
            checks++;
            if (o_wen !== 8'hF0) begin
               errors++;
               $display("FAIL partial_wen got %h want f0", o_wen);
            end
         end
         if (i == 3) begin
            checks++;
            if (o_rv0 !== 1'b1 || o_rd0 !== 64'h00000000FFFFFFFF) begin
               errors++;
               $display("FAIL partial_data got v=%b d=%h want 1 00000000ffffffff", o_rv0, o_rd0);
            end
         end
      end
   endtask

   task automatic test_contention();
      cyc(mk_wr(12'h010, 64'h1010_1010_AAAA_0000, 8'hFF), IDLE);
      cyc(IDLE, mk_wr(12'h020, 64'h2020_2020_BBBB_1111, 8'hFF));
      for (int i = 0; i < 8; i++) begin
         if (i < 6) cyc(mk_rd(12'h010), mk_rd(12'h020));
         else cyc(IDLE, IDLE);
         if (i < 6) begin
            checks++;
            if ({o_r0, o_r1} !== {i % 2 == 0, i % 2 == 1}) begin
               errors++;
               $display("FAIL cont_grant cyc %0d got %b%b want %b%b", i, o_r0, o_r1, i % 2 == 0, i % 2 == 1);
            end
         end
         if (i >= 1 && i <= 6) begin
            checks++;
            if ({o_rv0, o_rv1} !== {i % 2 == 1, i % 2 == 0}) begin
               errors++;
               $display("FAIL cont_rsp cyc %0d got %b%b want %b%b", i, o_rv0, o_rv1, i % 2 == 1, i % 2 == 0);
            end
         end
         checks++;
         if (o_rd0 !== exp_rd0 || o_rd1 !== exp_rd1) begin
            errors++;
            $display("FAIL cont_data cyc %0d got %h %h want %h %h", i, o_rd0, o_rd1, exp_rd0, exp_rd1);
         end
      end
      checks++;
      if (o_rd0 !== 64'h1010_1010_AAAA_0000 || o_rd1 !== 64'h2020_2020_BBBB_1111) begin
         errors++;
         $display("FAIL cont_final got %h %h want 10101010aaaa0000 20202020bbbb1111", o_rd0, o_rd1);
      end
   endtask

   task automatic test_back_to_back();
      int run;
      int best;
      run = 0; best = 0;
      for (int i = 0; i < 8; i++)
         cyc(mk_wr(12'(i), {32'hB2B0_0000, 32'(i * 3 + 1)}, 8'hFF), IDLE);
      for (int i = 0; i < 10; i++) begin
         cyc(IDLE, i < 8 ? mk_rd(12'(i)) : IDLE);
         checks++;
         if ({o_r0, o_r1} !== {exp_g0, exp_g1} || {o_cen, o_a} !== {exp_cen, exp_a}) begin
            errors++;
            $display("FAIL b2b_acc cyc %0d got rdy=%b%b a=%h want %b%b %h", i, o_r0, o_r1, o_a, exp_g0, exp_g1, exp_a);
         end
         checks++;
         if ({o_rv0, o_rv1} !== {exp_rv0, exp_rv1} || o_rd1 !== exp_rd1) begin
            errors++;
            $display("FAIL b2b_rsp cyc %0d got v=%b%b d=%h want %b%b %h", i, o_rv0, o_rv1, o_rd1, exp_rv0, exp_rv1, exp_rd1);
         end
         if (o_rv1 === 1'b1) begin
            run++;
            if (run > best) best = run;
         end else begin
            run = 0;
         end
      end
      checks++;
      if (best !== 8) begin
         errors++;
         $display("FAIL b2b_run got %0d consecutive pulses want 8", best);
      end
   endtask

   task automatic test_random();
      req_t c0, c1;
      c0 = IDLE; c1 = IDLE;
      for (int i = 0; i < 300; i++) begin
         if (!c0.v && $urandom_range(9) < 7)
            c0 = mk_wr(12'(12'h300 + $urandom_range(15)), {$urandom, $urandom}, 8'($urandom));
         if (!c1.v && $urandom_range(9) < 7)
            c1 = mk_wr(12'(12'h300 + $urandom_range(15)), {$urandom, $urandom}, 8'($urandom));
         if (c0.v && $urandom_range(1) == 0) c0.w = 1'b0;
         if (c1.v && $urandom_range(1) == 0) c1.w = 1'b0;
         cyc(c0, c1);
         checks++;
         if ({o_r0, o_r1} !== {exp_g0, exp_g1}) begin
            errors++;
            $display("FAIL rnd_ready cyc %0d got %b%b want %b%b", i, o_r0, o_r1, exp_g0, exp_g1);
         end
         checks++;
         if ({o_cen, o_wen, o_a, o_d} !== {exp_cen, exp_wen, exp_a, exp_d}) begin
            errors++;
            $display("FAIL rnd_sram cyc %0d got %b %h %h %h want %b %h %h %h", i, o_cen, o_wen, o_a, o_d, exp_cen, exp_wen, exp_a, exp_d);
         end
         checks++;
         if ({o_rv0, o_rv1} !== {exp_rv0, exp_rv1} || o_rd0 !== exp_rd0 || o_rd1 !== exp_rd1) begin
            errors++;
            $display("FAIL rnd_rsp cyc %0d got v=%b%b %h %h want %b%b %h %h", i, o_rv0, o_rv1, o_rd0, o_rd1, exp_rv0, exp_rv1, exp_rd0, exp_rd1);
         end
         if (exp_g0) c0 = IDLE;
         if (exp_g1) c1 = IDLE;
      end
      cyc(IDLE, IDLE);
      cyc(IDLE, IDLE);
      checks++;
      if (o_rd0 !== exp_rd0 || o_rd1 !== exp_rd1) begin
         errors++;
         $display("FAIL rnd_drain got %h %h want %h %h", o_rd0, o_rd1, exp_rd0, exp_rd1);
      end
   endtask

   task automatic test_reset_mid();
      int waited;
      cyc(mk_rd(12'h100), IDLE);
      #2;
      rst_n = 1'b0;
      watch = 1'b1;
      #1;
      checks++;
      if ({rdy0, rdy1, rv0, rv1, done} !== 5'b0 || rd0 !== 64'd0 || rd1 !== 64'd0) begin
         errors++;
         $display("FAIL rst_run_out got flags=%b rd=%h %h want 00000 0 0", {rdy0, rdy1, rv0, rv1, done}, rd0, rd1);
      end
      checks++;
      if (cen !== 1'b1 || wen !== 8'hFF || sa !== 12'd0 || sd !== 64'd0) begin
         errors++;
         $display("FAIL rst_run_sram got %b %h %h %h want 1 ff 0 0", cen, wen, sa, sd);
      end
      drive(IDLE, IDLE);
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (cen !== 1'b0 || sa !== 12'd5) begin
         errors++;
         $display("FAIL rst_fill_pos got cen=%b a=%h want 0 005", cen, sa);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (cen !== 1'b1 || wen !== 8'hFF || sa !== 12'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL rst_fill_out got %b %h %h done=%b want 1 ff 0 0", cen, wen, sa, done);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (cen !== 1'b0 || sa !== 12'd0 || wen !== 8'h00) begin
         errors++;
         $display("FAIL rst_fill_restart got cen=%b a=%h wen=%h want 0 000 00", cen, sa, wen);
      end
      waited = 0;
      while (done !== 1'b1 && waited < 40) begin
         @(posedge clk);
         #1;
         waited++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL rst_done_timeout got %b want 1 within 40 cycles", done);
      end
      watch = 1'b0;
      checks++;
      if (pulses !== 0) begin
         errors++;
         $display("FAIL rst_no_rsp got %0d pulses want 0", pulses);
      end
      for (int i = 0; i <= LAST; i++) ref_mem[i] = '0;
      for (int i = 0; i < 4; i++) begin
         cyc(i == 0 ? mk_rd(12'h100) : IDLE, i < 2 ? mk_rd(12'h003) : IDLE);
         checks++;
         if ({o_r0, o_r1} !== {exp_g0, exp_g1}) begin
            errors++;
            $display("FAIL rst_tie cyc %0d got %b%b want %b%b", i, o_r0, o_r1, exp_g0, exp_g1);
         end
         checks++;
         if ({o_rv0, o_rv1} !== {exp_rv0, exp_rv1} || o_rd0 !== exp_rd0 || o_rd1 !== exp_rd1) begin
            errors++;
            $display("FAIL rst_after cyc %0d got v=%b%b %h %h want %b%b %h %h", i, o_rv0, o_rv1, o_rd0, o_rd1, exp_rv0, exp_rv1, exp_rd0, exp_rd1);
         end
      end
      checks++;
      if (o_rd0 !== 64'h0123456789ABCDEF || o_rd1 !== 64'd0) begin
         errors++;
         $display("FAIL rst_after_data got %h %h want 0123456789abcdef 0", o_rd0, o_rd1);
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         sram[i] = {8{8'hA5}};
         ref_mem[i] = {8{8'hA5}};
      end
      test_reset();
      test_zero_fill();
      test_write_read();
      test_partial_write();
      test_contention();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
